// File: rtl/registers.sv
// MIPS general-purpose register file: 32 x 32-bit, one combinational read port,
// one clocked write port whose destination is decoded from the instruction word.
module registers (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    input  logic        regwrite,
    input  logic [4:0]  address,
    input  logic [31:0] write_data,
    output logic [31:0] dataOut
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;

    logic [31:0] r_regs [32];
    logic [4:0]  w_dest;
    logic [5:0]  w_opcode;
    logic        w_wr_en;

    assign w_opcode = instruction[31:26];

    always_comb begin
        w_dest = instruction[20:16];
        case (w_opcode)
            OP_RTYPE: w_dest = instruction[15:11];
            OP_JAL:   w_dest = 5'd31;
            default:  w_dest = instruction[20:16];
        endcase
    end

    // Writes to register 0 are dropped so it stays zero after reset.
    assign w_wr_en = regwrite && (w_dest != 5'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[w_dest] <= write_data;
        end
    end

    // Register 0 reads zero even before the first reset edge.
    assign dataOut = (address == 5'd0) ? '0 : r_regs[address];

endmodule

// File: tb/tb_registers.sv
// Self-checking bench for the register file: directed test plan followed by
// randomized traffic checked against an array-based reference model.
module tb_registers;

    logic        clk;
    logic        rst_n;
    logic [31:0] instruction;
    logic        regwrite;
    logic [4:0]  address;
    logic [31:0] write_data;
    logic [31:0] dataOut;

    int unsigned n_checks;
    int unsigned n_pass;
    logic [31:0] model [32];

    registers dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instruction(instruction),
        .regwrite   (regwrite),
        .address    (address),
        .write_data (write_data),
        .dataOut    (dataOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    function automatic int unsigned dest_of(input logic [31:0] ins);
        int unsigned op;
        op = ins >> 26;
        if (op == 0) return (ins >> 11) % 32;
        if (op == 3) return 31;
        return (ins >> 16) % 32;
    endfunction

    // Apply one edge with the given controls, update the model, then idle inputs.
    task automatic cycle(input logic rn, input logic [31:0] ins, input logic we, input logic [31:0] wd);
        int unsigned d;
        rst_n = rn; instruction = ins; regwrite = we; write_data = wd;
        @(posedge clk);
        if (!rn) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (we) begin
            d = dest_of(ins);
            if (d != 0) model[d] = wd;
        end
        #1;
        rst_n = 1'b1; regwrite = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [4:0] a);
        address = a;
        #1;
        check(tag, dataOut, model[a]);
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        rst_n = 1'b0; instruction = '0; regwrite = 1'b0; address = '0; write_data = '0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;

        // 1. reset held for two edges, then sweep all addresses
        cycle(1'b0, 32'h0, 1'b0, 32'h0);
        cycle(1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 32; i++) begin
            address = 5'(i);
            #1;
            check($sformatf("reset_r%0d", i), dataOut, 32'h0);
        end

        // 2. R-type write
        cycle(1'b1, 32'h012A4020, 1'b1, 32'hDEADBEEF);
        address = 5'd8;  #1; check("rtype_r8", dataOut, 32'hDEADBEEF);
        address = 5'd10; #1; check("rtype_r10", dataOut, 32'h0);

        // 3. I-type and jal destinations
        cycle(1'b1, 32'h21090005, 1'b1, 32'h5);
        address = 5'd9; #1; check("addi_r9", dataOut, 32'h5);
        cycle(1'b1, 32'h0C000002, 1'b1, 32'h00400008);
        address = 5'd31; #1; check("jal_r31", dataOut, 32'h00400008);

        // 4. register 0 and write-enable gating
        cycle(1'b1, 32'h012A0020, 1'b1, 32'hFFFFFFFF);
        address = 5'd0; #1; check("r0_write", dataOut, 32'h0);
        cycle(1'b1, 32'h012A4020, 1'b0, 32'h00001234);
        address = 5'd8; #1; check("we_off_r8", dataOut, 32'hDEADBEEF);

        // 5. read-during-write: old value before edge, new value after
        address = 5'd8;
        instruction = 32'h012A4020; regwrite = 1'b1; write_data = 32'hCAFEF00D;
        #1; check("rdw_before", dataOut, 32'hDEADBEEF);
        cycle(1'b1, 32'h012A4020, 1'b1, 32'hCAFEF00D);
        check("rdw_after", dataOut, 32'hCAFEF00D);

        // 6. reset overrides a concurrent write
        cycle(1'b0, 32'h012A4020, 1'b1, 32'h55AA55AA);
        address = 5'd8; #1; check("rst_prio_r8", dataOut, 32'h0);
        address = 5'd31; #1; check("rst_prio_r31", dataOut, 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ins;
            logic [31:0] wd;
            logic        we;
            logic        rn;
            int unsigned sel;
            logic [4:0]  pa;
            sel = $urandom_range(0, 2);
            ins = $urandom;
            if (sel == 0) ins[31:26] = 6'h00;
            else if (sel == 1) ins[31:26] = 6'h03;
            wd = $urandom;
            we = ($urandom_range(0, 3) != 0);
            rn = ($urandom_range(0, 39) != 0);
            // pre-edge read must still show the model's old contents
            pa = 5'(dest_of(ins));
            rst_n = rn; instruction = ins; regwrite = we; write_data = wd; address = pa;
            #1;
            check("rnd_pre", dataOut, model[pa]);
            cycle(rn, ins, we, wd);
            rd("rnd_dest", pa);
            rd("rnd_any", 5'($urandom_range(0, 31)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
